lp_rx_sot_detect: RTL and testbench
===================================

Name: lp_rx_sot_detect

Overview:
- Receive-side LP line-state decoder. It sits directly downstream of the LP transmitter, on the far end of the lane.
- It samples the single-ended LP receiver outputs of Dp/Dn, synchronises and deglitches them, then tracks the LP-11 → LP-01 → LP-00 start-of-transmission sequence.
- It enables HS termination and the HS receiver, and detects HS exit on return to LP-11.
- It flags protocol errors to the upper layer.

Parameters:
- FILT_CYCLES, 2: consecutive synchronised samples a line state must hold before it is accepted (1..15).
- LPX_MIN, 8: minimum cycles of LP-01 before LP-00 is legal.
- TERM_DLY, 2: cycles after entering prepare before HSTERM_EN asserts.
- PREP_CYCLES, 6: cycles of prepare before HS active (must be > TERM_DLY).
- RQST_TIMEOUT, 64: maximum cycles allowed in the request state (<=255).

Ports:
- LPRX_CLK  in  1  LP receive clock; all state updates on posedge.
- RxRSt  in  1  asynchronous active-low reset.
- LPRX_EN  in  1  block enable; low holds the FSM idle.
- LP_Dp  in  1  asynchronous LP receiver output for Dp.
- LP_Dn  in  1  asynchronous LP receiver output for Dn.
- HSTERM_EN  out  1  enable HS line termination.
- HSRX_EN  out  1  enable HS data receiver.
- RxActiveHS  out  1  lane in HS receive.
- RxStopState  out  1  lane in stop state (LP-11).
- RxHsExit  out  1  one-cycle pulse on HS-to-stop exit.
- ErrControl  out  1  one-cycle pulse on illegal LP sequence.

Behaviour:
- Reset (RxRSt low, async):
  - All outputs 0.
  - Sync flops, filtered state and last-sample register set to 2'b11.
  - FSM to RX_STOP; timer 0; stability count 0.
- Line state notation: {Dp,Dn}.
- Synchroniser: 2-flop per line, giving s2.
- Filter:
  - stab_cnt resets to 1 when s2 differs from the previous s2; otherwise it increments, saturating at 15.
  - filt takes s2 on the edge where the updated stab_cnt >= FILT_CYCLES.
  - A stable input change reaches filt FILT_CYCLES+1 edges after first capture.
  - Pulses shorter than FILT_CYCLES cycles never reach filt.
- Timer: 8-bit, cleared on every state transition, incremented (saturating at 255) every cycle spent in a state.
- LPRX_EN low: synchronously force RX_STOP, timer 0, all outputs 0. Sync and filter keep running.
- RX_STOP:
  - RxStopState=1 while filt==11.
  - filt==01 → RX_HS_RQST.
  - filt==00 → RX_ERR.
  - filt==10 (escape request, not supported here) → remain, no flag.
- RX_HS_RQST:
  - filt==00 with timer>=LPX_MIN → RX_HS_PRPR.
  - filt==00 with timer<LPX_MIN → RX_ERR.
  - filt==11 → RX_STOP (abort, no error).
  - filt==10 → RX_ERR.
  - timer==RQST_TIMEOUT → RX_ERR.
- RX_HS_PRPR:
  - HSTERM_EN set on the edge where timer reaches TERM_DLY.
  - When timer reaches PREP_CYCLES → RX_HS_ACTIVE.
  - filt==01 or 10 → RX_ERR.
  - filt==11 → RX_STOP.
  - Line events take priority over timer events in the same cycle.
- RX_HS_ACTIVE:
  - HSTERM_EN=HSRX_EN=RxActiveHS=1.
  - Filt values 00/01/10 are ignored (HS swing is invisible to the LP receivers).
  - filt==11 → RX_STOP: HSTERM_EN, HSRX_EN and RxActiveHS drop and RxHsExit pulses on the same edge; RxStopState rises on that edge.
- RX_ERR:
  - ErrControl pulses on the entry edge only.
  - All enables 0.
  - Leave to RX_STOP only when filt==11.
- Outputs are registered, Moore-style. There is no combinational path from LP_Dp/LP_Dn to any output.
- Mid-operation behaviour:
  - Reset mid-operation: outputs clear immediately (async); the FSM restarts in RX_STOP after release.
  - LPRX_EN deassert mid-HS: enables drop on the next edge, with no RxHsExit pulse.

Test Plan (defaults):
- Reset:
  - Stimulus: RxRSt low with lines 11, then release with LPRX_EN=1.
  - Response: all outputs 0 during reset; RxStopState=1 on the first edge after release.
- Normal SoT/EoT:
  - Stimulus: 11 → 01 held 12 cycles → 00 held 20 cycles → 11.
  - Response:
    - HSTERM_EN rises 2 cycles after prepare entry; HSRX_EN/RxActiveHS rise 6 cycles after prepare entry.
    - On 11 being accepted: RxHsExit is a single 1-cycle pulse, RxStopState=1, ErrControl never asserted.
- Short LPX:
  - Stimulus: 01 held 4 cycles → 00.
  - Response: ErrControl 1-cycle pulse; HSTERM_EN/HSRX_EN stay 0. A later 11 returns RxStopState=1.
- Glitch rejection:
  - Stimulus: 1-cycle 01 pulse on a stable 11 line.
  - Response: filt stays 11; RxStopState stays 1; no state change.
- Request timeout:
  - Stimulus: 01 held 100 cycles.
  - Response: ErrControl pulses when the request timer reaches 64; no enables assert.
- Async reset mid-HS:
  - Stimulus: pull RxRSt low while RxActiveHS=1.
  - Response: HSRX_EN/HSTERM_EN/RxActiveHS go 0 without a clock edge; no RxHsExit pulse.

Source files
------------

// File: rtl/lp_rx_sot_detect.sv
// Receive-side LP line-state decoder: synchronises and deglitches Dp/Dn, follows the
// LP-11 -> LP-01 -> LP-00 start-of-transmission sequence and drives the HS receive enables.
module lp_rx_sot_detect #(
  parameter int FILT_CYCLES  = 2,
  parameter int LPX_MIN      = 8,
  parameter int TERM_DLY     = 2,
  parameter int PREP_CYCLES  = 6,
  parameter int RQST_TIMEOUT = 64
) (
  input  logic LPRX_CLK,
  input  logic RxRSt,
  input  logic LPRX_EN,
  input  logic LP_Dp,
  input  logic LP_Dn,
  output logic HSTERM_EN,
  output logic HSRX_EN,
  output logic RxActiveHS,
  output logic RxStopState,
  output logic RxHsExit,
  output logic ErrControl
);

  typedef enum logic [2:0] {
    RX_STOP,
    RX_HS_RQST,
    RX_HS_PRPR,
    RX_HS_ACTIVE,
    RX_ERR
  } state_t;

  localparam logic [3:0] FILT_C = 4'(FILT_CYCLES);
  localparam logic [7:0] LPX_C  = 8'(LPX_MIN);
  localparam logic [7:0] TERM_C = 8'(TERM_DLY);
  localparam logic [7:0] PREP_C = 8'(PREP_CYCLES);
  localparam logic [7:0] RQST_C = 8'(RQST_TIMEOUT);

  logic [1:0] s1, s2, prev, filt;
  logic [3:0] stab_cnt, stab_next;

  state_t     state, state_next;
  logic [7:0] timer, timer_inc, timer_next;
  logic       hsterm_next, hsrx_next, active_next, stop_next, exit_next, err_next;

  // A line state is accepted only after it has been seen FILT_CYCLES times in a row.
  always_comb begin
    stab_next = 4'd1;
    if (s2 == prev)
      stab_next = (stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1;
  end

  always_ff @(posedge LPRX_CLK or negedge RxRSt) begin
    if (!RxRSt) begin
      s1       <= 2'b11;
      s2       <= 2'b11;
      prev     <= 2'b11;
      filt     <= 2'b11;
      stab_cnt <= 4'd0;
    end else begin
      s1       <= {LP_Dp, LP_Dn};
      s2       <= s1;
      prev     <= s2;
      stab_cnt <= stab_next;
      if (stab_next >= FILT_C)
        filt <= s2;
    end
  end

  always_comb begin
    timer_inc  = (timer == 8'hff) ? timer : timer + 8'd1;
    state_next = state;
    case (state)
      RX_STOP: begin
        if (filt == 2'b01)      state_next = RX_HS_RQST;
        else if (filt == 2'b00) state_next = RX_ERR;
      end
      RX_HS_RQST: begin
        if (filt == 2'b00)         state_next = (timer >= LPX_C) ? RX_HS_PRPR : RX_ERR;
        else if (filt == 2'b11)    state_next = RX_STOP;
        else if (filt == 2'b10)    state_next = RX_ERR;
        else if (timer == RQST_C)  state_next = RX_ERR;
      end
      RX_HS_PRPR: begin
        // Line events win over the prepare timer.
        if (filt == 2'b01 || filt == 2'b10) state_next = RX_ERR;
        else if (filt == 2'b11)             state_next = RX_STOP;
        else if (timer_inc >= PREP_C)       state_next = RX_HS_ACTIVE;
      end
      RX_HS_ACTIVE: begin
        if (filt == 2'b11) state_next = RX_STOP;
      end
      RX_ERR: begin
        if (filt == 2'b11) state_next = RX_STOP;
      end
      default: state_next = RX_STOP;
    endcase
    if (!LPRX_EN)
      state_next = RX_STOP;

    timer_next = (state_next != state || !LPRX_EN) ? 8'd0 : timer_inc;

    // Outputs are decoded from the next state so they are registered alongside it.
    hsterm_next = (state_next == RX_HS_PRPR && timer_next >= TERM_C) || state_next == RX_HS_ACTIVE;
    hsrx_next   = (state_next == RX_HS_ACTIVE);
    active_next = (state_next == RX_HS_ACTIVE);
    stop_next   = LPRX_EN && state_next == RX_STOP && filt == 2'b11;
    exit_next   = LPRX_EN && state == RX_HS_ACTIVE && state_next == RX_STOP;
    err_next    = (state_next == RX_ERR) && (state != RX_ERR);
  end

  always_ff @(posedge LPRX_CLK or negedge RxRSt) begin
    if (!RxRSt) begin
      state       <= RX_STOP;
      timer       <= 8'd0;
      HSTERM_EN   <= 1'b0;
      HSRX_EN     <= 1'b0;
      RxActiveHS  <= 1'b0;
      RxStopState <= 1'b0;
      RxHsExit    <= 1'b0;
      ErrControl  <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      HSTERM_EN   <= hsterm_next;
      HSRX_EN     <= hsrx_next;
      RxActiveHS  <= active_next;
      RxStopState <= stop_next;
      RxHsExit    <= exit_next;
      ErrControl  <= err_next;
    end
  end

endmodule

// File: tb/tb_lp_rx_sot_detect.sv
// Directed bench for lp_rx_sot_detect: a vector table for the main SoT/EoT, glitch and
// error paths plus hand-written sequences for timeout, enable drop and async reset.
module tb_lp_rx_sot_detect;

  logic LPRX_CLK = 1'b0;
  logic RxRSt, LPRX_EN, LP_Dp, LP_Dn;
  logic HSTERM_EN, HSRX_EN, RxActiveHS, RxStopState, RxHsExit, ErrControl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 LPRX_CLK = ~LPRX_CLK;

  lp_rx_sot_detect dut (
    .LPRX_CLK   (LPRX_CLK),
    .RxRSt      (RxRSt),
    .LPRX_EN    (LPRX_EN),
    .LP_Dp      (LP_Dp),
    .LP_Dn      (LP_Dn),
    .HSTERM_EN  (HSTERM_EN),
    .HSRX_EN    (HSRX_EN),
    .RxActiveHS (RxActiveHS),
    .RxStopState(RxStopState),
    .RxHsExit   (RxHsExit),
    .ErrControl (ErrControl)
  );

  // {HSTERM_EN, HSRX_EN, RxActiveHS, RxStopState, RxHsExit, ErrControl}
  typedef struct {
    logic [1:0] line;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] outs();
    return {HSTERM_EN, HSRX_EN, RxActiveHS, RxStopState, RxHsExit, ErrControl};
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b (%0d) expected %b (%0d)", nm, 6'(got), got, 6'(exp), exp);
    end else begin
      $display("ok   %s: %b", nm, 6'(got));
    end
  endtask

  task automatic drive(input logic [1:0] l);
    {LP_Dp, LP_Dn} = l;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge LPRX_CLK);
    @(negedge LPRX_CLK);
  endtask

  task automatic goto_active();
    drive(2'b11); step(8);
    drive(2'b01); step(12);
    drive(2'b00); step(12);
    check("goto_active", outs(), 6'b111000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err, n_err, en_seen;

    // line, posedges to advance, expected outputs afterwards
    vecs.push_back('{2'b11, 1, 6'b000100});  // first edge after reset release
    vecs.push_back('{2'b11, 2, 6'b000100});
    vecs.push_back('{2'b01, 4, 6'b000100});  // filtered, FSM not yet moved
    vecs.push_back('{2'b01, 1, 6'b000000});  // request entered
    vecs.push_back('{2'b01, 7, 6'b000000});  // 01 held 12 cycles total
    vecs.push_back('{2'b00, 4, 6'b000000});
    vecs.push_back('{2'b00, 1, 6'b000000});  // prepare entry
    vecs.push_back('{2'b00, 1, 6'b000000});
    vecs.push_back('{2'b00, 1, 6'b100000});  // termination 2 after entry
    vecs.push_back('{2'b00, 3, 6'b100000});
    vecs.push_back('{2'b00, 1, 6'b111000});  // HS active 6 after entry
    vecs.push_back('{2'b00, 9, 6'b111000});
    vecs.push_back('{2'b11, 4, 6'b111000});
    vecs.push_back('{2'b11, 1, 6'b000110});  // exit pulse + stop
    vecs.push_back('{2'b11, 1, 6'b000100});  // exit pulse is one cycle
    vecs.push_back('{2'b01, 1, 6'b000100});  // one-cycle glitch
    vecs.push_back('{2'b11, 8, 6'b000100});
    vecs.push_back('{2'b01, 4, 6'b000100});  // short LPX
    vecs.push_back('{2'b00, 1, 6'b000000});
    vecs.push_back('{2'b00, 3, 6'b000000});
    vecs.push_back('{2'b00, 1, 6'b000001});  // error pulse
    vecs.push_back('{2'b00, 1, 6'b000000});
    vecs.push_back('{2'b00, 5, 6'b000000});
    vecs.push_back('{2'b11, 4, 6'b000000});
    vecs.push_back('{2'b11, 1, 6'b000100});  // back to stop
    vecs.push_back('{2'b01, 5, 6'b000000});  // request then abort
    vecs.push_back('{2'b11, 5, 6'b000100});
    vecs.push_back('{2'b00, 5, 6'b000001});  // 00 from stop is illegal
    vecs.push_back('{2'b11, 5, 6'b000100});

    RxRSt = 1'b0; LPRX_EN = 1'b1; drive(2'b11);
    step(3);
    check("reset_outputs", outs(), 6'b000000);
    RxRSt = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].line);
      step(vecs[i].n);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Request timeout: 01 held 100 cycles
    first_err = 0; n_err = 0; en_seen = 0;
    drive(2'b01);
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (ErrControl) begin
        n_err++;
        if (first_err == 0) first_err = c;
      end
      if (HSTERM_EN || HSRX_EN) en_seen = 1;
    end
    check("timeout_at", int'(first_err == 69 || first_err == 70), 1);
    check("timeout_pulses", n_err, 1);
    check("timeout_no_en", en_seen, 0);
    drive(2'b11); step(5);
    check("timeout_recover", outs(), 6'b000100);

    // Enable drop mid-HS: enables fall, no exit pulse
    goto_active();
    LPRX_EN = 1'b0;
    step(1);
    check("en_drop", outs(), 6'b000000);
    drive(2'b11); step(6);
    check("en_low_idle", outs(), 6'b000000);
    LPRX_EN = 1'b1;
    step(1);
    check("en_restore", outs(), 6'b000100);

    // Async reset mid-HS: outputs clear without a clock edge
    goto_active();
    #2 RxRSt = 1'b0;
    #1 check("async_reset", outs(), 6'b000000);
    drive(2'b11);
    @(negedge LPRX_CLK);
    check("reset_hold", outs(), 6'b000000);
    RxRSt = 1'b1;
    step(1);
    check("reset_release", outs(), 6'b000100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
